// File: rtl/pc_unit.sv
// Program counter for the IF stage: sequential stepping, prioritised redirects
// (exc > eret > branch > jump), and redirects deferred across pipeline stalls.
module pc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h80)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] pc_next,
  output logic             fetch_valid,
  output logic             redirected,
  output logic             misalign
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [2:0] CODE_EXC  = 3'd4;
  localparam logic [2:0] CODE_ERET = 3'd3;
  localparam logic [2:0] CODE_BR   = 3'd2;
  localparam logic [2:0] CODE_JMP  = 3'd1;
  localparam logic [2:0] CODE_NONE = 3'd0;

  // STEP is a power of two, so STEP-1 covers exactly the ALIGN low bits.
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [2:0]       pend_code_q, pend_code_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             redirected_q, redirected_d;
  logic             misalign_q, misalign_d;

  logic [2:0]       req_code;
  logic [WIDTH-1:0] req_tgt;
  logic [2:0]       win_code;
  logic [WIDTH-1:0] win_tgt;
  logic             load;
  logic             req_wins;

  always_comb begin
    req_code = CODE_NONE;
    req_tgt  = jump_target;
    if (exc) begin
      req_code = CODE_EXC;
      req_tgt  = EXC_VEC;
    end else if (eret) begin
      req_code = CODE_ERET;
      req_tgt  = epc;
    end else if (branch) begin
      req_code = CODE_BR;
      req_tgt  = branch_target;
    end else if (jump) begin
      req_code = CODE_JMP;
      req_tgt  = jump_target;
    end
  end

  assign pc_plus  = pc_q + STEP_W;
  assign req_wins = (req_code != CODE_NONE) && (req_code >= pend_code_q);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_tgt_d    = pend_tgt_q;
    pend_code_d   = pend_code_q;
    fetch_valid_d = fetch_valid_q;
    redirected_d  = 1'b0;
    misalign_d    = 1'b0;
    load          = 1'b0;
    win_code      = req_code;
    win_tgt       = req_tgt;

    case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN: begin
        if (!stall) begin
          if (req_code != CODE_NONE) begin
            load = 1'b1;
          end else begin
            pc_d = pc_plus;
          end
        end else if (exc) begin
          load = 1'b1;
        end else if (req_code != CODE_NONE) begin
          pend_tgt_d  = req_tgt;
          pend_code_d = req_code;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        // exc always outranks pending, so it takes this path even under stall.
        if (!stall || exc) begin
          load        = 1'b1;
          state_d     = RUN;
          pend_tgt_d  = '0;
          pend_code_d = CODE_NONE;
          if (!req_wins) begin
            win_code = pend_code_q;
            win_tgt  = pend_tgt_q;
          end
        end else if (req_wins) begin
          pend_tgt_d  = req_tgt;
          pend_code_d = req_code;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    if (load) begin
      redirected_d = 1'b1;
      if (win_code == CODE_EXC) begin
        pc_d = win_tgt;
      end else begin
        pc_d       = win_tgt & ~LOW_MASK;
        misalign_d = |(win_tgt & LOW_MASK);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VEC;
      pend_tgt_q    <= '0;
      pend_code_q   <= CODE_NONE;
      fetch_valid_q <= 1'b0;
      redirected_q  <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_tgt_q    <= pend_tgt_d;
      pend_code_q   <= pend_code_d;
      fetch_valid_q <= fetch_valid_d;
      redirected_q  <= redirected_d;
      misalign_q    <= misalign_d;
    end
  end

  assign pc          = pc_q;
  assign pc_next     = pc_d;
  assign fetch_valid = fetch_valid_q;
  assign redirected  = redirected_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit and an 8-bit instance share stimulus;
// a vector table covers stepping/redirect/stall cases, then a reset-in-HOLD sequence.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall, exc, eret, branch, jump;
  logic [31:0] epc, branch_target, jump_target;

  logic [31:0] pc, pc_plus, pc_next;
  logic        fetch_valid, redirected, misalign;
  logic [7:0]  pc8, pc_plus8, pc_next8;
  logic        fetch_valid8, redirected8, misalign8;

  int errors = 0;
  int checks = 0;

  pc_unit #(
    .WIDTH(32), .STEP(4), .RESET_VEC(32'h0), .EXC_VEC(32'h80)
  ) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .exc(exc), .eret(eret), .epc(epc),
    .branch(branch), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .pc(pc), .pc_plus(pc_plus), .pc_next(pc_next),
    .fetch_valid(fetch_valid), .redirected(redirected), .misalign(misalign)
  );

  pc_unit #(
    .WIDTH(8), .STEP(4), .RESET_VEC(8'h0), .EXC_VEC(8'h80)
  ) u_dut8 (
    .clk(clk), .rst(rst), .stall(stall), .exc(exc), .eret(eret), .epc(epc[7:0]),
    .branch(branch), .branch_target(branch_target[7:0]), .jump(jump),
    .jump_target(jump_target[7:0]), .pc(pc8), .pc_plus(pc_plus8), .pc_next(pc_next8),
    .fetch_valid(fetch_valid8), .redirected(redirected8), .misalign(misalign8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          stall, exc, eret, branch, jump;
    logic [31:0] epc, bt, jt;
    logic [31:0] exp_pc;
    bit          exp_redir, exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; exc = 0; eret = 0; branch = 0; jump = 0;
    epc = '0; branch_target = '0; jump_target = '0;
  endtask

  initial begin
    //                stl exc ert br jmp epc           bt            jt            pc            rd mis
    vecs.push_back(vec_t'{0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h300,      32'h0,        0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h8,        0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'hC,        0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 1, 1, 32'h0,        32'h40,       32'h80,       32'h40,       1, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h44,       0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h100,      32'h44,       0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h44,       0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 1, 0, 32'h0,        32'h200,      32'h0,        32'h44,       0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h200,      1, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h204,      0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 1, 0, 32'h0,        32'h200,      32'h0,        32'h204,      0, 0});
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h80,       1, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h80,       0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h84,       0, 0});
    vecs.push_back(vec_t'{1, 0, 1, 0, 0, 32'h500,      32'h0,        32'h0,        32'h84,       0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h600,      32'h84,       0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 1, 0, 32'h0,        32'h700,      32'h0,        32'h500,      1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 0, 32'h12,       32'h0,        32'h0,        32'h10,       1, 1});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h14,       0, 0});
    vecs.push_back(vec_t'{1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h20,       32'h14,       0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h30,       32'h30,       1, 0});
    vecs.push_back(vec_t'{0, 1, 1, 0, 0, 32'h900,      32'h0,        32'h0,        32'h80,       1, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 1, 32'h0,        32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h13,       32'h10,       1, 1});

    idle_inputs();
    rst = 1'b1;
    #2;
    check("reset pc", pc, 32'h0);
    check("reset fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("reset redirected", {31'b0, redirected}, 32'h0);
    check("reset misalign", {31'b0, misalign}, 32'h0);
    check("reset pc8", {24'b0, pc8}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      stall = vecs[i].stall; exc = vecs[i].exc; eret = vecs[i].eret;
      branch = vecs[i].branch; jump = vecs[i].jump;
      epc = vecs[i].epc; branch_target = vecs[i].bt; jump_target = vecs[i].jt;
      #1;
      check($sformatf("v%0d pc_next", i), pc_next, vecs[i].exp_pc);
      @(posedge clk);
      #1;
      check($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d pc_plus", i), pc_plus, vecs[i].exp_pc + 32'd4);
      check($sformatf("v%0d redirected", i), {31'b0, redirected}, {31'b0, vecs[i].exp_redir});
      check($sformatf("v%0d misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
      check($sformatf("v%0d fetch_valid", i), {31'b0, fetch_valid}, 32'h1);
      check($sformatf("v%0d pc8", i), {24'b0, pc8}, {24'b0, vecs[i].exp_pc[7:0]});
      check($sformatf("v%0d misalign8", i), {31'b0, misalign8}, {31'b0, vecs[i].exp_mis});
    end

    // Reset while a stalled eret is pending: it must never reach pc.
    @(negedge clk);
    idle_inputs();
    stall = 1; eret = 1; epc = 32'h700;
    @(posedge clk);
    #1;
    check("hold pc", pc, 32'h10);
    @(negedge clk);
    eret = 0;
    #2;
    rst = 1'b1;
    #1;
    check("async rst pc", pc, 32'h0);
    check("async rst fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("async rst pc8", {24'b0, pc8}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    stall = 0;
    @(posedge clk);
    #1;
    check("post-rst boot pc", pc, 32'h0);
    check("post-rst boot fetch_valid", {31'b0, fetch_valid}, 32'h1);
    check("post-rst boot redirected", {31'b0, redirected}, 32'h0);
    @(posedge clk);
    #1;
    check("post-rst step pc", pc, 32'h4);
    check("post-rst step redirected", {31'b0, redirected}, 32'h0);
    @(posedge clk);
    #1;
    check("post-rst step2 pc", pc, 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
